// File: rtl/rx_lane_deskew.sv
// Multi-lane RX deskew: per-lane elastic FIFOs that are released in lock-step
// once every active lane has delivered the COM alignment marker.
module rx_lane_deskew #(
  parameter int LANES = 16,
  parameter int SYMS  = 4,
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4:0]              numberOfDetectedLanes,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*8*SYMS-1:0] in_data,
  input  logic [LANES*SYMS-1:0]   in_datak,
  output logic                    out_valid,
  output logic [LANES*8*SYMS-1:0] out_data,
  output logic [LANES*SYMS-1:0]   out_datak,
  output logic                    aligned,
  output logic                    deskew_error,
  output logic [CNTW-1:0]         skew_cycles
);
  localparam int DW = 8 * SYMS;
  localparam int WW = DW + SYMS;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     PTR_ONE   = 1;
  localparam logic [AW:0]     FULL_XOR  = {1'b1, {AW{1'b0}}};
  localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, WAIT, ALIGNED} state_t;
  state_t state;

  logic [WW-1:0]    mem [LANES][DEPTH];
  logic [AW:0]      wptr [LANES];
  logic [AW:0]      rptr [LANES];
  logic [LANES-1:0] seen;
  logic [CNTW-1:0]  cnt;
  logic [4:0]       n_q;

  logic [LANES-1:0] active, is_mk, hd_mk, full, empty, wr, seen_nxt;
  logic [WW-1:0]    in_word [LANES];
  logic [WW-1:0]    hd_word [LANES];
  logic             all_seen, any_seen, rd, mk_bad, ovf, restart, err_now, flush;
  logic [CNTW-1:0]  cnt_nxt;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      active[i]   = (int'(numberOfDetectedLanes) > i);
      in_word[i]  = {in_datak[i*SYMS +: SYMS], in_data[i*DW +: DW]};
      hd_word[i]  = mem[i][rptr[i][AW-1:0]];
      is_mk[i]    = in_word[i][DW] && (in_word[i][7:0] == 8'hBC);
      hd_mk[i]    = hd_word[i][DW] && (hd_word[i][7:0] == 8'hBC);
      full[i]     = ((wptr[i] ^ rptr[i]) == FULL_XOR);
      empty[i]    = (wptr[i] == rptr[i]);
      // while hunting, a lane only starts filling at its own marker
      wr[i]       = in_valid[i] && active[i] &&
                    ((state == ALIGNED) ||
                     (((state == SEARCH) || (state == WAIT)) && (seen[i] || is_mk[i])));
      seen_nxt[i] = seen[i] || (wr[i] && is_mk[i]);
    end
    all_seen = &(seen_nxt | ~active);
    any_seen = |(seen_nxt & active);
    rd       = (state == ALIGNED) && (|active) && (&(~empty | ~active));
    mk_bad   = rd && (|(active & (hd_mk ^ {LANES{hd_mk[0]}})));
    ovf      = |(wr & full & ~(active & {LANES{rd}}));
    cnt_nxt  = cnt + CNTW'(1);
    restart  = !enable || (numberOfDetectedLanes != n_q);
    unique case (state)
      WAIT:    err_now = ovf || (cnt_nxt == CNT_LIMIT);
      ALIGNED: err_now = ovf || mk_bad;
      default: err_now = 1'b0;
    endcase
    flush = restart || err_now;
  end

  // Lane storage carries no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (wr[i]) mem[i][wptr[i][AW-1:0]] <= in_word[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      n_q          <= '0;
      cnt          <= '0;
      seen         <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_datak    <= '0;
      aligned      <= 1'b0;
      deskew_error <= 1'b0;
      skew_cycles  <= '0;
      for (int i = 0; i < LANES; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      n_q          <= numberOfDetectedLanes;
      out_valid    <= 1'b0;
      deskew_error <= err_now && !restart;
      if (flush) begin
        seen <= '0;
        for (int i = 0; i < LANES; i++) begin
          wptr[i] <= '0;
          rptr[i] <= '0;
        end
      end else begin
        seen <= seen_nxt;
        for (int i = 0; i < LANES; i++) begin
          if (wr[i])             wptr[i] <= wptr[i] + PTR_ONE;
          if (rd && active[i])   rptr[i] <= rptr[i] + PTR_ONE;
        end
      end

      if (restart) begin
        state   <= IDLE;
        aligned <= 1'b0;
      end else if (err_now) begin
        state   <= SEARCH;
        aligned <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (numberOfDetectedLanes != 5'd0) state <= SEARCH;
          SEARCH: begin
            if (all_seen) begin
              state       <= ALIGNED;
              aligned     <= 1'b1;
              skew_cycles <= '0;
            end else if (any_seen) begin
              state <= WAIT;
              cnt   <= '0;
            end
          end
          WAIT: begin
            cnt <= cnt_nxt;
            if (all_seen) begin
              state       <= ALIGNED;
              aligned     <= 1'b1;
              skew_cycles <= cnt_nxt;
            end
          end
          ALIGNED: begin
            if (rd) begin
              out_valid <= 1'b1;
              for (int i = 0; i < LANES; i++) begin
                out_data[i*DW +: DW]      <= active[i] ? hd_word[i][DW-1:0] : '0;
                out_datak[i*SYMS +: SYMS] <= active[i] ? hd_word[i][WW-1:DW] : '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_lane_deskew.sv
// Randomized lane-stream bench for rx_lane_deskew, checked every cycle against
// a queue-based model of the deskew rules.
module tb_rx_lane_deskew;
  localparam int LANES = 16;
  localparam int SYMS  = 4;
  localparam int DEPTH = 8;
  localparam int CNTW  = $clog2(DEPTH) + 1;
  localparam int DW    = 8 * SYMS;
  localparam int WW    = DW + SYMS;
  localparam int OW    = LANES * DW;
  localparam int KW    = LANES * SYMS;
  localparam int P     = 12;
  localparam int M_IDLE = 0, M_SEARCH = 1, M_WAIT = 2, M_ALIGNED = 3;

  typedef logic [WW-1:0] word_t;

  logic             clk = 1'b0;
  logic             reset, enable;
  logic [4:0]       nl;
  logic [LANES-1:0] in_valid;
  logic [OW-1:0]    in_data, out_data;
  logic [KW-1:0]    in_datak, out_datak;
  logic             out_valid, aligned, deskew_error;
  logic [CNTW-1:0]  skew_cycles;

  rx_lane_deskew #(.LANES(LANES), .SYMS(SYMS), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .numberOfDetectedLanes(nl),
    .in_valid(in_valid), .in_data(in_data), .in_datak(in_datak),
    .out_valid(out_valid), .out_data(out_data), .out_datak(out_datak),
    .aligned(aligned), .deskew_error(deskew_error), .skew_cycles(skew_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ph_err = 0;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_marker(input word_t w);
    return w[DW] && (w[7:0] == 8'hBC);
  endfunction

  // Reference model: one queue per lane plus the acquisition mode.
  word_t           mq [LANES][$];
  bit              got_mk [LANES];
  int              mode, wcnt, prev_n;
  logic            e_valid, e_aligned, e_err;
  logic [CNTW-1:0] e_skew;
  logic [OW-1:0]   e_data;
  logic [KW-1:0]   e_datak;

  task automatic model_flush();
    for (int i = 0; i < LANES; i++) begin
      mq[i].delete();
      got_mk[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    model_flush();
    mode = M_IDLE; wcnt = 0; prev_n = 0;
    e_valid = 0; e_aligned = 0; e_err = 0; e_skew = '0; e_data = '0; e_datak = '0;
  endtask

  task automatic model_step();
    int    n;
    bit    chg, ovf, bad, pop, all, any;
    word_t w [LANES];
    word_t h;
    n = int'(nl);
    chg = !enable || (n != prev_n);
    prev_n = n;
    ovf = 0; bad = 0; pop = 1; all = 1; any = 0;
    e_valid = 0; e_err = 0;
    for (int i = 0; i < LANES; i++) w[i] = {in_datak[i*SYMS +: SYMS], in_data[i*DW +: DW]};
    if (chg) begin
      model_flush();
      mode = M_IDLE;
      e_aligned = 0;
    end else if (mode == M_IDLE) begin
      if (n > 0) mode = M_SEARCH;
    end else if (mode == M_SEARCH || mode == M_WAIT) begin
      if (mode == M_WAIT) wcnt++;
      for (int i = 0; i < n; i++)
        if (in_valid[i] && (got_mk[i] || is_marker(w[i])) && mq[i].size() == DEPTH) ovf = 1;
      if (mode == M_WAIT && (ovf || wcnt == DEPTH - 1)) begin
        e_err = 1;
        model_flush();
        mode = M_SEARCH;
      end else begin
        for (int i = 0; i < n; i++)
          if (in_valid[i] && (got_mk[i] || is_marker(w[i]))) begin
            mq[i].push_back(w[i]);
            got_mk[i] = 1;
          end
        for (int i = 0; i < n; i++) begin
          all &= got_mk[i];
          any |= got_mk[i];
        end
        if (all) begin
          e_skew = (mode == M_WAIT) ? CNTW'(wcnt) : '0;
          mode = M_ALIGNED;
          e_aligned = 1;
        end else if (any && mode == M_SEARCH) begin
          mode = M_WAIT;
          wcnt = 0;
        end
      end
    end else begin
      for (int i = 0; i < n; i++) if (mq[i].size() == 0) pop = 0;
      for (int i = 0; i < n; i++) if (in_valid[i] && mq[i].size() == DEPTH && !pop) ovf = 1;
      if (pop)
        for (int i = 1; i < n; i++) if (is_marker(mq[i][0]) != is_marker(mq[0][0])) bad = 1;
      if (ovf || bad) begin
        e_err = 1;
        model_flush();
        mode = M_SEARCH;
        e_aligned = 0;
      end else begin
        if (pop) begin
          e_valid = 1; e_data = '0; e_datak = '0;
          for (int i = 0; i < n; i++) begin
            h = mq[i].pop_front();
            e_data[i*DW +: DW]      = h[DW-1:0];
            e_datak[i*SYMS +: SYMS] = h[WW-1:DW];
          end
        end
        for (int i = 0; i < n; i++) if (in_valid[i]) mq[i].push_back(w[i]);
      end
    end
  endtask

  // Transmitter: a common word stream per cycle, each lane delayed by its own backlog.
  word_t pend [LANES][$];
  int    hold [LANES];
  int    gap_pct [LANES];
  bit    corrupt [LANES];
  int    t;

  task automatic drive_inputs();
    logic [DW-1:0]   base, d;
    logic [SYMS-1:0] kb, k;
    bit              mk;
    word_t           w;
    mk   = ((t % P) == 3);
    base = DW'($urandom);
    kb   = SYMS'($urandom) & ~SYMS'(1);
    for (int i = 0; i < LANES; i++) begin
      d = mk ? {base[DW-1:8], 8'hBC} : base;
      d = d ^ (DW'(i) << (DW - 8));
      k = mk ? SYMS'(1) : kb;
      pend[i].push_back({k, d});
      in_valid[i] = 1'b0;
      in_data[i*DW +: DW]      = DW'($urandom);
      in_datak[i*SYMS +: SYMS] = SYMS'($urandom);
      if (hold[i] > 0) hold[i]--;
      else if (gap_pct[i] > 0 && int'($urandom_range(0, 99)) < gap_pct[i]) ;
      else if (pend[i].size() > 0) begin
        w = pend[i].pop_front();
        if (corrupt[i] && is_marker(w)) begin
          w[7:0] = 8'h4A;
          w[DW]  = 1'b0;
          corrupt[i] = 0;
        end
        in_valid[i] = 1'b1;
        in_data[i*DW +: DW]      = w[DW-1:0];
        in_datak[i*SYMS +: SYMS] = w[WW-1:DW];
      end
    end
    t++;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_inputs();
    model_step();
    @(posedge clk);
    #1;
    check("out_valid", OW'(out_valid), OW'(e_valid));
    check("aligned", OW'(aligned), OW'(e_aligned));
    check("deskew_error", OW'(deskew_error), OW'(e_err));
    check("skew_cycles", OW'(skew_cycles), OW'(e_skew));
    check("out_data", out_data, e_data);
    check("out_datak", OW'(out_datak), OW'(e_datak));
    if (deskew_error) ph_err++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_tx();
    for (int i = 0; i < LANES; i++) begin
      pend[i].delete();
      hold[i] = 0; gap_pct[i] = 0; corrupt[i] = 0;
    end
  endtask

  task automatic start_phase(input int n);
    nl = 5'(n);
    enable = 1'b0;
    clear_tx();
    cycle();
    enable = 1'b1;
    clear_tx();
    t = 0;
    ph_err = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, OW'(out_valid), '0);
    check({tag, "_aligned"}, OW'(aligned), '0);
    check({tag, "_error"}, OW'(deskew_error), '0);
    check({tag, "_skew"}, OW'(skew_cycles), '0);
    check({tag, "_data"}, out_data, '0);
    check({tag, "_datak"}, OW'(out_datak), '0);
  endtask

  initial begin
    int k;
    reset = 1'b0; enable = 1'b0; nl = '0; t = 0;
    in_valid = '0; in_data = '0; in_datak = '0;
    clear_tx();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // all lanes marker on the same cycle
    start_phase(4);
    run(40);
    check("A_skew", OW'(skew_cycles), OW'(0));
    check("A_aligned", OW'(aligned), OW'(1));
    check("A_errs", OW'(ph_err), OW'(0));

    // lane 2 three cycles late
    start_phase(4);
    hold[2] = 3;
    run(40);
    check("B_skew", OW'(skew_cycles), OW'(3));
    check("B_errs", OW'(ph_err), OW'(0));

    // skew beyond tolerance, then pulled back to 2
    start_phase(2);
    hold[1] = 7;
    run(40);
    check("C_err_seen", OW'(ph_err != 0), OW'(1));
    repeat (5) void'(pend[1].pop_front());
    ph_err = 0;
    run(40);
    check("C_skew", OW'(skew_cycles), OW'(2));
    check("C_aligned", OW'(aligned), OW'(1));
    check("C_errs", OW'(ph_err), OW'(0));

    // corrupted marker on lane 1 while aligned
    start_phase(4);
    run(30);
    corrupt[1] = 1;
    ph_err = 0;
    run(40);
    check("D_errs", OW'(ph_err), OW'(1));
    check("D_aligned", OW'(aligned), OW'(1));

    // valid gaps on lane 3
    start_phase(4);
    run(30);
    gap_pct[3] = 30;
    run(100);
    check("E_err_seen", OW'(ph_err != 0), OW'(1));

    // lane count change mid-stream
    start_phase(4);
    run(30);
    nl = 5'd8;
    ph_err = 0;
    run(40);
    check("F_aligned", OW'(aligned), OW'(1));
    check("F_skew", OW'(skew_cycles), OW'(0));
    check("F_errs", OW'(ph_err), OW'(0));

    // random lane counts and skews
    for (int r = 0; r < 3; r++) begin
      start_phase(int'($urandom_range(1, 16)));
      for (int i = 0; i < LANES; i++) hold[i] = int'($urandom_range(0, 5));
      run(50);
    end

    // asynchronous reset while waiting for late markers
    start_phase(4);
    hold[2] = 5;
    k = 0;
    while (mode != M_WAIT && k < 20) begin
      cycle();
      k++;
    end
    check("H_reached_wait", OW'(mode == M_WAIT), OW'(1));
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    enable = 1'b0;
    reset = 1'b1;
    start_phase(4);
    run(30);
    check("H_aligned", OW'(aligned), OW'(1));
    check("H_skew", OW'(skew_cycles), OW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
